multi_pwm_dimmer: RTL and testbench

MULTI_PWM_DIMMER -- requirements
Module: multi_pwm_dimmer

---
 rtl/multi_pwm_dimmer.sv | 122 ++++++++++++
 tb/tb_multi_pwm_dimmer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_pwm_dimmer.sv
// Multi-channel PWM dimmer: one shared period counter drives N_CH channels.
// Each channel either jumps to or fades toward its target duty, one step per fade interval.

module multi_pwm_dimmer_lane #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             boundary,
    input  logic             fade_step,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_duty,
    input  logic             wr_fade,
    input  logic [WIDTH-1:0] cnt,
    output logic             pwm,
    output logic             fading
);
    logic [WIDTH-1:0] act, act_nxt;
    logic [WIDTH-1:0] tgt, tgt_nxt;
    logic             mode, mode_nxt;

    // act only moves on a boundary and always from the pre-write tgt/mode
    always_comb begin
        tgt_nxt  = wr ? wr_duty : tgt;
        mode_nxt = wr ? wr_fade : mode;
        act_nxt  = act;
        if (boundary) begin
            if (!mode)
                act_nxt = tgt;
            else if (fade_step && act < tgt)
                act_nxt = act + 1'b1;
            else if (fade_step && act > tgt)
                act_nxt = act - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act    <= '0;
            tgt    <= '0;
            mode   <= 1'b0;
            pwm    <= 1'b0;
            fading <= 1'b0;
        end else begin
            act    <= act_nxt;
            tgt    <= tgt_nxt;
            mode   <= mode_nxt;
            pwm    <= en && (cnt < act);
            // flag tracks the state being loaded, so it never lags the ramp
            fading <= mode_nxt && (act_nxt != tgt_nxt);
        end
    end
endmodule

module multi_pwm_dimmer #(
    parameter int N_CH     = 4,
    parameter int WIDTH    = 4,
    parameter int FADE_DIV = 1,
    localparam int CW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            wr_en,
    input  logic [CW-1:0]   wr_ch,
    input  logic [WIDTH-1:0] wr_duty,
    input  logic            wr_fade,
    input  logic [CW-1:0]   sel,
    output logic [N_CH-1:0] pwm_out,
    output logic            led_out,
    output logic            period_tick,
    output logic [N_CH-1:0] fading
);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [7:0]       DIV_LAST = 8'(FADE_DIV - 1);

    logic [WIDTH-1:0] cnt;
    logic [7:0]       div;
    logic             boundary;
    logic             fade_step;

    assign boundary    = en && (cnt == CNT_MAX);
    assign fade_step   = boundary && (div == DIV_LAST);
    assign period_tick = boundary;

    // en=0 parks the counter at 0 so a resume starts a full period
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (!en)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            div <= '0;
        else if (boundary)
            div <= (div == DIV_LAST) ? 8'd0 : div + 8'd1;
    end

    // out-of-range wr_ch matches no lane, so the write is dropped
    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        multi_pwm_dimmer_lane #(.WIDTH(WIDTH)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .boundary  (boundary),
            .fade_step (fade_step),
            .wr        (wr_en && (wr_ch == CW'(i))),
            .wr_duty   (wr_duty),
            .wr_fade   (wr_fade),
            .cnt       (cnt),
            .pwm       (pwm_out[i]),
            .fading    (fading[i])
        );
    end

    assign led_out = (int'(sel) < N_CH) ? pwm_out[sel] : 1'b0;
endmodule

// File: tb/tb_multi_pwm_dimmer.sv
// Directed bench for multi_pwm_dimmer (N_CH=4, WIDTH=4, FADE_DIV=1).
// Inputs change and outputs are sampled on the falling edge.

module tb_multi_pwm_dimmer;
    logic       clk = 1'b0;
    logic       rst_n, en, wr_en, wr_fade;
    logic [1:0] wr_ch, sel;
    logic [3:0] wr_duty;
    logic [3:0] pwm_out, fading;
    logic       led_out, period_tick;

    int checks = 0;
    int errors = 0;
    int hi[4];
    int low_pos[4];
    int led, ticks, tick_pos, j;

    multi_pwm_dimmer #(.N_CH(4), .WIDTH(4), .FADE_DIV(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_duty     (wr_duty),
        .wr_fade     (wr_fade),
        .sel         (sel),
        .pwm_out     (pwm_out),
        .led_out     (led_out),
        .period_tick (period_tick),
        .fading      (fading)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int c = 0; c < 4; c++) begin
            hi[c] = 0;
            low_pos[c] = -1;
        end
        led = 0; ticks = 0; tick_pos = -1; j = 0;
    endtask

    // advance one cycle and tally what the outputs show after the edge
    task automatic step();
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            if (pwm_out[c]) hi[c]++;
            else low_pos[c] = j;
        end
        if (led_out) led++;
        if (period_tick) begin
            if (ticks == 0) tick_pos = j;
            ticks++;
        end
        j++;
    endtask

    task automatic write(input int ch, input int duty, input int fade);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_duty = 4'(duty);
        wr_fade = fade[0];
        step();
        wr_en   = 1'b0;
    endtask

    task automatic run16();
        clr();
        repeat (16) step();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 4'd9;
        wr_fade = 1'b0; sel = 2'd0;
        clr();
        repeat (2) step();
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_fading", int'(fading), 0);
        chk("rst_tick", int'(period_tick), 0);

        // release: cnt=0 cycle now, tick expected on the 16th cycle
        rst_n = 1'b1; wr_en = 1'b0;
        chk("rel_tick0", int'(period_tick), 0);
        clr();
        repeat (15) step();
        chk("first_tick_pos", tick_pos, 14);
        chk("rst_write_ignored", hi[0], 0);

        // jump write mid-period: rest of the period stays low
        repeat (5) step();
        clr();
        write(0, 5, 0);
        for (int k = 0; k < 40 && !period_tick; k++) step();
        chk("jump_align", int'(period_tick), 1);
        step();
        chk("jump_rest_low", hi[0], 0);
        run16();
        chk("jump_p1_hi", hi[0], 5);
        chk("jump_led", led, 5);
        run16();
        chk("jump_p2_hi", hi[0], 5);

        // extremes: ch1=0, ch2=15
        clr();
        write(1, 0, 0);
        write(2, 15, 0);
        repeat (14) step();
        sel = 2'd2;
        run16();
        chk("ext_ch1_hi", hi[1], 0);
        chk("ext_ch2_hi", hi[2], 15);
        chk("ext_ch2_lowpos", low_pos[2], 15);
        chk("ext_led_ch2", led, 15);
        chk("ext_ch0_hi", hi[0], 5);
        sel = 2'd3;

        // fade ch3 0 -> 3
        clr();
        write(3, 3, 1);
        chk("fade_flag_set", int'(fading[3]), 1);
        repeat (15) step();
        chk("fade_p0_hi", hi[3], 0);
        run16();
        chk("fade_p1_hi", hi[3], 1);
        chk("fade_flag_mid", int'(fading[3]), 1);
        run16();
        chk("fade_p2_hi", hi[3], 2);
        chk("fade_flag_done", int'(fading[3]), 0);
        run16();
        chk("fade_p3_hi", hi[3], 3);
        chk("fade_led_ch3", led, 3);
        run16();
        chk("fade_hold_hi", hi[3], 3);

        // retarget up to 7, then reverse down to 1
        clr();
        write(3, 7, 1);
        repeat (15) step();
        chk("rt_p4_hi", hi[3], 3);
        run16();
        chk("rt_p5_hi", hi[3], 4);
        clr();
        write(3, 1, 1);
        repeat (15) step();
        chk("rt_p6_hi", hi[3], 5);
        run16();
        chk("rev_p7_hi", hi[3], 4);
        run16();
        chk("rev_p8_hi", hi[3], 3);

        // en=0 for 7 cycles mid-fade (act=2, tgt=1)
        en = 1'b0;
        clr();
        repeat (7) step();
        chk("dis_pwm_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);
        chk("dis_ticks", ticks, 0);
        chk("dis_fading", int'(fading[3]), 1);
        en = 1'b1;
        run16();
        chk("resume_act_held", hi[3], 2);
        chk("resume_ch0", hi[0], 5);
        chk("resume_tick_pos", tick_pos, 14);

        // write ch0=8 in the period_tick cycle
        clr();
        repeat (15) step();
        chk("bw_tick", int'(period_tick), 1);
        clr();
        write(0, 8, 0);
        run16();
        chk("bw_old_duty", hi[0], 5);
        run16();
        chk("bw_new_duty", hi[0], 8);
        chk("rev_settled", hi[3], 1);

        // reset mid-ramp
        clr();
        write(3, 12, 1);
        repeat (20) step();
        chk("pre_rst_fading", int'(fading[3]), 1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_pwm", int'(pwm_out), 0);
        chk("mid_rst_fading", int'(fading), 0);
        chk("mid_rst_tick", int'(period_tick), 0);
        rst_n = 1'b1;
        run16();
        chk("post_rst_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);
        chk("post_rst_tick_pos", tick_pos, 14);
        chk("post_rst_fading", int'(fading), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
